// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the PC counter, the program ROM and the decoder.
interface fetch_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] pc_value;
  logic             pc_load;
  logic [WIDTH-1:0] pc_load_value;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             fetch_enable;
  logic             branch_take;
  logic [WIDTH-1:0] branch_target;
  logic             instr_valid;
  logic             instr_ready;
  logic [WIDTH-1:0] instr_opcode;
  logic [WIDTH-1:0] instr_operand;
  logic [WIDTH-1:0] instr_pc;

  modport master (
    input  pc_value, mem_rdata, fetch_enable, branch_take, branch_target, instr_ready,
    output pc_load, pc_load_value, mem_addr, instr_valid, instr_opcode, instr_operand, instr_pc
  );

  modport slave (
    output pc_value, mem_rdata, fetch_enable, branch_take, branch_target, instr_ready,
    input  pc_load, pc_load_value, mem_addr, instr_valid, instr_opcode, instr_operand, instr_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers a free-running PC counter and assembles 1- or 2-byte
// instructions from a synchronous ROM into a valid/ready stream for the decoder.
module fetch_sequencer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned ARG_FLAG_BIT = 7
) (
  input logic                clock,
  input logic                reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {StAddr, StOp, StArg, StValid} state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] opcode_q, opcode_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;

  assign bus.mem_addr      = bus.pc_value;
  assign bus.instr_valid   = valid_q;
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_operand = operand_q;
  assign bus.instr_pc      = ipc_q;

  always_comb begin
    state_d           = state_q;
    opcode_d          = opcode_q;
    operand_d         = operand_q;
    ipc_d             = ipc_q;
    // Counter increments unless loaded, so holding means reloading its own value.
    bus.pc_load       = 1'b1;
    bus.pc_load_value = bus.pc_value;

    unique case (state_q)
      StAddr: begin
        if (bus.fetch_enable) begin
          bus.pc_load = 1'b0;
          state_d     = StOp;
        end
      end
      StOp: begin
        opcode_d = bus.mem_rdata;
        ipc_d    = bus.pc_value - WIDTH'(1);
        if (bus.mem_rdata[ARG_FLAG_BIT]) begin
          bus.pc_load = 1'b0;
          state_d     = StArg;
        end else begin
          operand_d = '0;
          state_d   = StValid;
        end
      end
      StArg: begin
        operand_d = bus.mem_rdata;
        state_d   = StValid;
      end
      StValid: begin
        if (bus.instr_ready) begin
          if (bus.fetch_enable) begin
            bus.pc_load = 1'b0;
            state_d     = StOp;
          end else begin
            state_d = StAddr;
          end
        end
      end
      default: state_d = StAddr;
    endcase

    if (bus.branch_take) begin
      bus.pc_load       = 1'b1;
      bus.pc_load_value = bus.branch_target;
      state_d           = StAddr;
    end

    valid_d = (state_d == StValid);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StAddr;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      ipc_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a behavioural PC counter and program ROM.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_sequencer_if #(.WIDTH(8)) bus ();

  fetch_sequencer #(.WIDTH(8), .ARG_FLAG_BIT(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [7:0]  rom [256];
  logic [23:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // Counter: no enable, increments unless loaded, cleared by the same reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            bus.pc_value <= 8'h00;
    else if (bus.pc_load) bus.pc_value <= bus.pc_load_value;
    else                  bus.pc_value <= bus.pc_value + 8'h01;
  end

  always_ff @(posedge clock) bus.mem_rdata <= rom[bus.mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every handshake pops one expected {opcode, operand, instr_pc}.
  always @(negedge clock) begin
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got 0x%0h, expected none",
                 {bus.instr_opcode, bus.instr_operand, bus.instr_pc});
      end else begin
        check("instr", {8'h00, bus.instr_opcode, bus.instr_operand, bus.instr_pc},
              {8'h00, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.instr_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    if (!bus.instr_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid after %0d cycles, expected valid", cycles);
    end
  endtask

  task automatic accept(input logic en_after);
    bus.fetch_enable = en_after;
    bus.instr_ready  = 1'b1;
    tick();
    bus.instr_ready  = 1'b0;
  endtask

  task automatic branch(input logic [7:0] target);
    bus.branch_take   = 1'b1;
    bus.branch_target = target;
    tick();
    bus.branch_take   = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [7:0] hold_op, hold_pc;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h34;
    rom[8'h05] = 8'h85; rom[8'h06] = 8'hAA;
    rom[8'h07] = 8'h81; rom[8'h08] = 8'h55;
    rom[8'h40] = 8'h05;
    rom[8'hFF] = 8'h90;
    bus.fetch_enable  = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch_take   = 1'b0;
    bus.branch_target = 8'h00;

    tick(); tick();
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_opcode", {24'd0, bus.instr_opcode}, 32'd0);
    check("rst_operand", {24'd0, bus.instr_operand}, 32'd0);
    check("rst_ipc", {24'd0, bus.instr_pc}, 32'd0);

    // Sequential 1-byte fetch from 0
    reset = 1'b0;
    bus.fetch_enable = 1'b1;
    exp_q.push_back({8'h12, 8'h00, 8'h00});
    wait_valid(cyc);
    check("lat_1byte", cyc, 32'd2);
    exp_q.push_back({8'h34, 8'h00, 8'h01});
    accept(1'b1);
    wait_valid(cyc);

    // Stall with ready low
    hold_op = bus.instr_opcode;
    hold_pc = bus.pc_value;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("stall_opcode", {24'd0, bus.instr_opcode}, {24'd0, hold_op});
      check("stall_pc", {24'd0, bus.pc_value}, {24'd0, hold_pc});
    end
    accept(1'b1);
    check("pc_after_accept", {24'd0, bus.pc_value}, {24'd0, hold_pc + 8'h01});
    wait_valid(cyc);

    // Branch away from an unaccepted instruction to a 2-byte one
    branch(8'h05);
    check("br_valid_drop", {31'd0, bus.instr_valid}, 32'd0);
    check("br_pc", {24'd0, bus.pc_value}, 32'h05);
    exp_q.push_back({8'h85, 8'hAA, 8'h05});
    wait_valid(cyc);
    check("lat_2byte", cyc, 32'd3);
    accept(1'b0);
    check("next_fetch_pc", {24'd0, bus.pc_value}, 32'h07);
    tick(); tick();
    check("idle_hold_pc", {24'd0, bus.pc_value}, 32'h07);
    check("idle_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Branch while collecting an operand
    bus.fetch_enable = 1'b1;
    tick(); tick();
    branch(8'h40);
    check("arg_br_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("arg_br_pc", {24'd0, bus.pc_value}, 32'h40);
    exp_q.push_back({8'h05, 8'h00, 8'h40});
    wait_valid(cyc);
    accept(1'b0);

    // 2-byte opcode at 0xFF wraps to operand at 0x00
    rom[8'h00] = 8'h11;
    bus.fetch_enable = 1'b1;
    branch(8'hFF);
    exp_q.push_back({8'h90, 8'h11, 8'hFF});
    wait_valid(cyc);
    accept(1'b0);
    check("wrap_pc", {24'd0, bus.pc_value}, 32'h01);
    bus.fetch_enable = 1'b1;
    exp_q.push_back({8'h34, 8'h00, 8'h01});
    wait_valid(cyc);
    accept(1'b0);

    // Asynchronous reset in the operand state
    bus.fetch_enable = 1'b1;
    branch(8'h05);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("arst_opcode", {24'd0, bus.instr_opcode}, 32'd0);
    check("arst_operand", {24'd0, bus.instr_operand}, 32'd0);
    check("arst_ipc", {24'd0, bus.instr_pc}, 32'd0);
    check("arst_pc", {24'd0, bus.pc_value}, 32'd0);
    tick();
    reset = 1'b0;
    exp_q.push_back({8'h11, 8'h00, 8'h00});
    wait_valid(cyc);
    check("restart_lat", cyc, 32'd2);
    accept(1'b0);
    tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
